// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: CPU-side memory bus (request, data and completion signals).
interface mem_io_responder_if;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic        Mem_CE;
  logic        Mem_OE;
  logic        Mem_WE;
  logic        Mem_UB;
  logic        Mem_LB;
  logic [15:0] Data_to_CPU;
  logic        R;
  logic        Busy;
  modport master (output MAR, MDR, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB,
                  input  Data_to_CPU, R, Busy);
  modport slave  (input  MAR, MDR, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB,
                  output Data_to_CPU, R, Busy);
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: LC-3 memory bus responder with wait states, word RAM and memory-mapped I/O.
// Define RESP_IO_MAP_EN to map Switches/HEX_data at IO_ADDR; otherwise IO_ADDR is out of range.
module mem_io_responder #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  mem_io_responder_if.slave     bus,
  input  logic [15:0]           Switches,
  output logic [15:0]           HEX_data
);
  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, DONE, RELEASE} state_t;
  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);
  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [15:0] addr, wdata, mask, ram_q, io_q, rdata;
  logic        ub, lb, wr, req, leave, is_io, is_ram;
  logic [15:0] mem [2**ADDR_W];

  assign req    = !bus.Mem_CE && (!bus.Mem_OE || !bus.Mem_WE);
  assign leave  = state == ACCESS;
  assign mask   = {{8{~ub}}, {8{~lb}}};
  assign is_ram = addr[15:ADDR_W] == '0 && addr != IO_ADDR;
  assign ram_q  = mem[addr[ADDR_W-1:0]];
  assign rdata  = (is_ram ? ram_q : is_io ? io_q : 16'h0000) & mask;
  assign bus.R    = state == DONE;
  assign bus.Busy = state != IDLE;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE:    if (req) state_n = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
      WAIT: begin
        state_n = (cnt == WLAST) ? ACCESS : WAIT;
        cnt_n   = (cnt == WLAST) ? 4'd0 : cnt + 4'd1;
      end
      ACCESS:  state_n = DONE;
      DONE:    state_n = RELEASE;
      RELEASE: state_n = bus.Mem_CE ? IDLE : RELEASE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state           <= IDLE;
      cnt             <= '0;
      addr            <= '0;
      wdata           <= '0;
      ub              <= 1'b1;
      lb              <= 1'b1;
      wr              <= 1'b0;
      bus.Data_to_CPU <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && req) begin
        addr  <= bus.MAR;
        wdata <= bus.MDR;
        ub    <= bus.Mem_UB;
        lb    <= bus.Mem_LB;
        wr    <= !bus.Mem_WE;
      end
      if (leave && !wr) bus.Data_to_CPU <= rdata;
    end

  // RAM is never cleared; the Reset guard drops a write whose exit edge coincides with reset
  always_ff @(posedge Clk)
    if (leave && wr && is_ram && !Reset) mem[addr[ADDR_W-1:0]] <= (ram_q & ~mask) | (wdata & mask);

`ifdef RESP_IO_MAP_EN
  logic [15:0] sw_q1, sw_q2;
  assign is_io = addr == IO_ADDR;
  assign io_q  = sw_q2;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      sw_q1    <= '0;
      sw_q2    <= '0;
      HEX_data <= '0;
    end else begin
      sw_q1 <= Switches;
      sw_q2 <= sw_q1;
      if (leave && wr && is_io) HEX_data <= (HEX_data & ~mask) | (wdata & mask);
    end
`else
  logic unused_sw;
  assign unused_sw = ^Switches;
  assign is_io     = 1'b0;
  assign io_q      = '0;
  assign HEX_data  = '0;
`endif
endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the LC-3 CPU's memory bus. Accepts single-word read/write requests, and completes each after a fixed, programmable number of wait states with a one-cycle ready pulse. Requests are presented on the CPU's MAR/MDR outputs with active-low chip, output and write enables. Backs requests with an on-chip word RAM plus a memory-mapped I/O word (switches in, hex-display register out), and sits between the CPU datapath's MDR input path and the board I/O.

## Interface
- ADDR_W, 10, RAM address bits; RAM depth 2^ADDR_W 16-bit words
- WAIT_CYCLES, 2, wait states inserted before each access (0..15)
- IO_ADDR, 16'hFFFF, address of the memory-mapped I/O word
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- MAR  in  16  request address
- MDR  in  16  write data
- Mem_CE  in  1  chip enable, active low
- Mem_OE  in  1  read enable, active low
- Mem_WE  in  1  write enable, active low
- Mem_UB  in  1  upper-byte lane enable, active low
- Mem_LB  in  1  lower-byte lane enable, active low
- Switches  in  16  board switches, asynchronous
- Data_to_CPU  out  16  read data, registered
- R  out  1  ready pulse, one cycle per completed access
- Busy  out  1  high in any state other than IDLE
- HEX_data  out  16  hex-display register

## Operation
- States: IDLE, WAIT, ACCESS, DONE, RELEASE.
- IDLE: a request is Mem_CE=0 and (Mem_OE=0 or Mem_WE=0); with both OE and WE low it is a write.
- On accepting a request, latch MAR, MDR, UB, LB and the read/write type. Later changes to bus inputs are ignored until RELEASE exits.
- IDLE→WAIT on request, or IDLE→ACCESS when WAIT_CYCLES=0.
- WAIT counts WAIT_CYCLES cycles (4-bit counter), then →ACCESS. ACCESS→DONE unconditionally. DONE→RELEASE unconditionally.
- RELEASE→IDLE when Mem_CE=1. A request held asserted is never serviced twice.
- Decode on the latched address:
  - equal to IO_ADDR → I/O;
  - else if MAR[15:ADDR_W]==0 → RAM word MAR[ADDR_W-1:0];
  - else out of range.
- Write, performed on the edge leaving ACCESS:
  - updates the upper byte if UB=0 and the lower byte if LB=0;
  - both lanes disabled → no change;
  - targets the RAM, or HEX_data for I/O;
  - out-of-range writes are dropped.
- Read, registered into Data_to_CPU on the edge leaving ACCESS:
  - returns the RAM word, or the synchronized Switches for I/O;
  - disabled byte lanes read as 0x00;
  - out-of-range reads return 16'h0000.
- Data_to_CPU holds its value until the next completed read; writes do not alter it.
- Switches pass through a two-flop synchronizer; I/O reads see the value two edges old.
- Every accepted request produces exactly one R pulse, including out-of-range and no-lane requests.

## Timing
- Reset values: Data_to_CPU=0, R=0, Busy=0, HEX_data=0, state IDLE, counter 0, synchronizer flops 0. RAM contents are not cleared.
- Request sampled at edge E0 → ACCESS entered at edge E0+WAIT_CYCLES → R high for the cycle after edge E0+WAIT_CYCLES+1.
- Data_to_CPU is valid in the same cycle R is high.
- Busy rises after E0 and falls after the edge at which RELEASE sees Mem_CE=1.
- Reset asserted mid-operation: immediate return to IDLE with outputs at reset values.
  - Reset before the ACCESS-exit edge → the write is not performed.
  - Reset after that edge → the write stands.
- Back-to-back requests: minimum spacing is WAIT_CYCLES+4 cycles, including one cycle with Mem_CE high.

## Configuration
- RESP_IO_MAP_EN defined: I/O decode as above.
- RESP_IO_MAP_EN undefined:
  - IO_ADDR decodes as out of range (reads 0, writes dropped);
  - HEX_data is constant 0;
  - the Switches synchronizer is removed.
- Timing and R behaviour are identical in both builds.

## Test plan
- Reset, then write MAR=16'h0005, MDR=16'hBEEF, WE=0, UB=LB=0; release; read MAR=16'h0005 → R pulse exactly WAIT_CYCLES+1 edges after sampling, Data_to_CPU=16'hBEEF.
- Write 16'h1234 to 16'h0007 with UB=0, LB=1, after a prior full write of 16'hAAAA; read with both lanes enabled → 16'h12AA. Read with LB=1 → 16'h1200.
- With RESP_IO_MAP_EN: Switches=16'h00F3, read IO_ADDR → 16'h00F3; write 16'h0C0D to IO_ADDR → HEX_data=16'h0C0D. Without the macro: the read returns 16'h0000 and HEX_data stays 0.
- Hold Mem_CE=0, OE=0 for 20 cycles at MAR=16'h0005 → exactly one R pulse, Busy high until CE rises.
- Read MAR=16'h8000 (out of range) → R pulse, Data_to_CPU=16'h0000. A write there leaves RAM word 0 unchanged.
- Start a write of 16'h5555 to 16'h0003, assert Reset during WAIT → no R, Busy=0, Data_to_CPU=0; a subsequent read of 16'h0003 returns the prior contents.
